// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL responder: decodes Get/PutFullData/PutPartialData on channel A,
// executes against a word-addressed SRAM and returns acks through a 2-entry queue.
//
// Handshake rules: a beat transfers on a rising edge where valid and ready are
// both high. a_ready depends only on the registered queue count, never on
// a_valid. d_valid and all d_* fields come from the queue head and hold steady
// while d_valid is high and d_ready is low.
module tl_ul_sram_responder #(
    parameter int ADDR_W     = 26,
    parameter int SOURCE_W   = 2,
    parameter int DEPTH_LOG2 = 8,
    parameter logic [ADDR_W-1:0] BASE = '0
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [2:0]          a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [3:0]          a_mask,
    input  logic [31:0]         a_data,
    input  logic                a_corrupt,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [2:0]          d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic                d_sink,
    output logic                d_denied,
    output logic [31:0]         d_data,
    output logic                d_corrupt
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    logic [31:0] r_mem [0:WORDS-1];

    logic [1:0]          r_count;
    logic                r_wptr;
    logic                r_rptr;
    logic                r_q_is_data [0:1];
    logic [2:0]          r_q_size    [0:1];
    logic [SOURCE_W-1:0] r_q_source  [0:1];
    logic                r_q_denied  [0:1];
    logic [31:0]         r_q_data    [0:1];
    logic                r_q_corrupt [0:1];

    logic                  w_a_fire;
    logic                  w_d_fire;
    logic                  w_is_get;
    logic                  w_is_put;
    logic                  w_in_range;
    logic                  w_aligned;
    logic [3:0]            w_full_mask;
    logic                  w_mask_ok;
    logic                  w_legal;
    logic                  w_denied;
    logic [DEPTH_LOG2-1:0] w_word_idx;
    logic [31:0]           w_rdata;
    logic                  w_write;
    logic [31:0]           w_entry_data;

    assign a_ready  = (r_count < 2'd2);
    assign d_valid  = (r_count != 2'd0);
    assign w_a_fire = a_valid & a_ready;
    assign w_d_fire = d_valid & d_ready;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_is_get   = (a_opcode == OP_GET);
    assign w_is_put   = (a_opcode == OP_PUT_FULL) | (a_opcode == OP_PUT_PARTIAL);
    assign w_in_range = (a_address[ADDR_W-1:DEPTH_LOG2+2] == BASE[ADDR_W-1:DEPTH_LOG2+2]);
    assign w_word_idx = a_address[DEPTH_LOG2+1:2];

    always_comb begin
        w_aligned   = 1'b0;
        w_full_mask = 4'h0;
        case (a_size)
            3'd0: begin
                w_aligned   = 1'b1;
                w_full_mask = 4'b0001 << a_address[1:0];
            end
            3'd1: begin
                w_aligned   = (a_address[0] == 1'b0);
                w_full_mask = a_address[1] ? 4'hC : 4'h3;
            end
            3'd2: begin
                w_aligned   = (a_address[1:0] == 2'b00);
                w_full_mask = 4'hF;
            end
            default: begin
                w_aligned   = 1'b0;
                w_full_mask = 4'h0;
            end
        endcase
    end

    // Only PutFullData is constrained to the exact lane set of its size.
    assign w_mask_ok = (a_opcode != OP_PUT_FULL) | (a_mask == w_full_mask);
    assign w_legal   = (w_is_get | w_is_put) & (a_param == 3'd0) & (a_size <= 3'd2) &
                       w_aligned & w_in_range & w_mask_ok;
    assign w_denied  = ~w_legal;

    // ------------------------------------------------------------------
    // SRAM: combinational read, byte-masked write on the accepting edge
    // ------------------------------------------------------------------
    assign w_rdata      = r_mem[w_word_idx];
    assign w_write      = w_a_fire & w_is_put & ~w_denied & ~a_corrupt;
    assign w_entry_data = (w_is_get & ~w_denied) ? w_rdata : 32'h0;

    always_ff @(posedge clock) begin
        if (w_write) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mask[b]) begin
                    r_mem[w_word_idx][8*b +: 8] <= a_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response queue: 2 entries, 1-bit wrapping pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_q_is_data[i] <= 1'b0;
                r_q_size[i]    <= 3'd0;
                r_q_source[i]  <= '0;
                r_q_denied[i]  <= 1'b0;
                r_q_data[i]    <= 32'h0;
                r_q_corrupt[i] <= 1'b0;
            end
        end else begin
            if (w_a_fire) begin
                r_q_is_data[r_wptr] <= w_is_get;
                r_q_size[r_wptr]    <= a_size;
                r_q_source[r_wptr]  <= a_source;
                r_q_denied[r_wptr]  <= w_denied;
                r_q_data[r_wptr]    <= w_entry_data;
                r_q_corrupt[r_wptr] <= w_is_get & w_denied;
                r_wptr              <= ~r_wptr;
            end
            if (w_d_fire) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_a_fire, w_d_fire})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Outputs are forced to zero when the queue is empty so idle D reads 0.
    assign d_opcode  = d_valid ? {2'b00, r_q_is_data[r_rptr]} : 3'd0;
    assign d_param   = 2'd0;
    assign d_size    = d_valid ? r_q_size[r_rptr] : 3'd0;
    assign d_source  = d_valid ? r_q_source[r_rptr] : '0;
    assign d_sink    = 1'b0;
    assign d_denied  = d_valid ? r_q_denied[r_rptr] : 1'b0;
    assign d_data    = d_valid ? r_q_data[r_rptr] : 32'h0;
    assign d_corrupt = d_valid ? r_q_corrupt[r_rptr] : 1'b0;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Self-checking bench for tl_ul_sram_responder: table of single transactions,
// then backpressure, streaming and mid-operation reset sequences.
module tb_tl_ul_sram_responder;

  logic        clock;
  logic        reset_n;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [1:0]  a_source;
  logic [25:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_corrupt;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [1:0]  d_source;
  logic        d_sink;
  logic        d_denied;
  logic [31:0] d_data;
  logic        d_corrupt;

  tl_ul_sram_responder #(
    .ADDR_W(26), .SOURCE_W(2), .DEPTH_LOG2(8), .BASE(26'h0000000)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] W10 = 32'hDE22BE44;
  localparam logic [31:0] W20 = 32'hAAAABB78;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [1:0]  src;
    logic [25:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
    logic        eop;
    logic        eden;
    logic [31:0] edata;
    logic        ecorr;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  // scoreboard entries: {source, data}
  logic [33:0] exp_q [$];

  function automatic vec_t mk(input logic [2:0] op, input logic [2:0] param, input logic [2:0] size,
                              input logic [1:0] src, input logic [25:0] addr, input logic [3:0] mask,
                              input logic [31:0] data, input logic corrupt, input logic eop,
                              input logic eden, input logic [31:0] edata, input logic ecorr);
    vec_t v;
    v.op = op; v.param = param; v.size = size; v.src = src; v.addr = addr; v.mask = mask;
    v.data = data; v.corrupt = corrupt; v.eop = eop; v.eden = eden; v.edata = edata; v.ecorr = ecorr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_a(input vec_t v);
    int cyc;
    @(negedge clock);
    a_opcode = v.op; a_param = v.param; a_size = v.size; a_source = v.src;
    a_address = v.addr; a_mask = v.mask; a_data = v.data; a_corrupt = v.corrupt;
    a_valid = 1'b1;
    cyc = 0;
    while (!a_ready && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    if (!a_ready) begin
      fail_now("a_ready timeout");
      a_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1 a_valid = 1'b0;
    end
  endtask

  task automatic check_d(input vec_t v, input int idx);
    @(negedge clock);
    check($sformatf("v%0d d_valid", idx), {31'd0, d_valid}, 32'd1);
    check($sformatf("v%0d d_opcode", idx), {29'd0, d_opcode}, {31'd0, v.eop});
    check($sformatf("v%0d d_denied", idx), {31'd0, d_denied}, {31'd0, v.eden});
    check($sformatf("v%0d d_data", idx), d_data, v.edata);
    check($sformatf("v%0d d_corrupt", idx), {31'd0, d_corrupt}, {31'd0, v.ecorr});
    check($sformatf("v%0d d_source", idx), {30'd0, d_source}, {30'd0, v.src});
    check($sformatf("v%0d d_size", idx), {29'd0, d_size}, {29'd0, v.size});
    check($sformatf("v%0d d_param_sink", idx), {29'd0, d_param, d_sink}, 32'd0);
    d_ready = 1'b1;
    @(posedge clock);
    #1 d_ready = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    logic fa, fd;
    int   sent, recv, ncyc;

    // op param size src addr mask data corrupt | eop eden edata ecorr
    vecs[0]  = mk(3'd0, 3'd0, 3'd2, 2'd1, 26'h010, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    vecs[1]  = mk(3'd4, 3'd0, 3'd2, 2'd2, 26'h010, 4'hF, 32'h0,        1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
    vecs[2]  = mk(3'd1, 3'd0, 3'd2, 2'd0, 26'h010, 4'h5, 32'h11223344, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    vecs[3]  = mk(3'd4, 3'd0, 3'd2, 2'd3, 26'h010, 4'hF, 32'h0,        1'b0, 1'b1, 1'b0, W10, 1'b0);
    vecs[4]  = mk(3'd4, 3'd0, 3'd2, 2'd1, 26'h402, 4'hF, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0, 1'b1);
    vecs[5]  = mk(3'd0, 3'd0, 3'd2, 2'd2, 26'h410, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    vecs[6]  = mk(3'd4, 3'd0, 3'd2, 2'd0, 26'h010, 4'hF, 32'h0,        1'b0, 1'b1, 1'b0, W10, 1'b0);
    vecs[7]  = mk(3'd0, 3'd0, 3'd2, 2'd1, 26'h010, 4'h7, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    vecs[8]  = mk(3'd4, 3'd0, 3'd2, 2'd2, 26'h010, 4'hF, 32'h0,        1'b0, 1'b1, 1'b0, W10, 1'b0);
    vecs[9]  = mk(3'd0, 3'd0, 3'd2, 2'd3, 26'h020, 4'hF, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    vecs[10] = mk(3'd0, 3'd1, 3'd2, 2'd0, 26'h020, 4'hF, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    vecs[11] = mk(3'd4, 3'd0, 3'd2, 2'd1, 26'h020, 4'hF, 32'h0,        1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0);
    vecs[12] = mk(3'd0, 3'd0, 3'd1, 2'd2, 26'h022, 4'hC, 32'hAAAA5555, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    vecs[13] = mk(3'd0, 3'd0, 3'd0, 2'd3, 26'h021, 4'h2, 32'h0000BB00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    vecs[14] = mk(3'd4, 3'd0, 3'd1, 2'd0, 26'h022, 4'hC, 32'h0,        1'b0, 1'b1, 1'b0, W20, 1'b0);
    vecs[15] = mk(3'd0, 3'd0, 3'd2, 2'd1, 26'h020, 4'hF, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    vecs[16] = mk(3'd4, 3'd0, 3'd2, 2'd2, 26'h020, 4'hF, 32'h0,        1'b0, 1'b1, 1'b0, W20, 1'b0);
    vecs[17] = mk(3'd4, 3'd0, 3'd3, 2'd3, 26'h020, 4'hF, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0, 1'b1);
    vecs[18] = mk(3'd0, 3'd0, 3'd1, 2'd0, 26'h021, 4'h3, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    vecs[19] = mk(3'd0, 3'd0, 3'd1, 2'd1, 26'h022, 4'h3, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    vecs[20] = mk(3'd4, 3'd0, 3'd2, 2'd2, 26'h2000010, 4'hF, 32'h0,    1'b0, 1'b1, 1'b1, 32'h0, 1'b1);

    reset_n = 1'b0; a_valid = 1'b0; d_ready = 1'b0;
    a_opcode = 3'd0; a_param = 3'd0; a_size = 3'd0; a_source = 2'd0;
    a_address = 26'h0; a_mask = 4'h0; a_data = 32'h0; a_corrupt = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst d_valid", {31'd0, d_valid}, 32'd0);
    check("rst a_ready", {31'd0, a_ready}, 32'd1);
    check("rst d_fields", {22'd0, d_opcode, d_size, d_source, d_denied, d_corrupt}, 32'd0);
    check("rst d_data", d_data, 32'h0);
    reset_n = 1'b1;

    // ---- table-driven single transactions ----
    for (int i = 0; i < NV; i++) begin
      send_a(vecs[i]);
      check_d(vecs[i], i);
    end

    // ---- backpressure and ordering ----
    d_ready = 1'b0;
    a_opcode = 3'd4; a_param = 3'd0; a_size = 3'd2; a_mask = 4'hF; a_corrupt = 1'b0; a_data = 32'h0;
    @(negedge clock);
    check("bp a_ready empty", {31'd0, a_ready}, 32'd1);
    a_source = 2'd0; a_address = 26'h010; a_valid = 1'b1;
    @(posedge clock);
    exp_q.push_back({2'd0, W10});
    @(negedge clock);
    check("bp a_ready one", {31'd0, a_ready}, 32'd1);
    check("bp d_valid one", {31'd0, d_valid}, 32'd1);
    a_source = 2'd1; a_address = 26'h020;
    @(posedge clock);
    exp_q.push_back({2'd1, W20});
    @(negedge clock);
    check("bp a_ready full", {31'd0, a_ready}, 32'd0);
    a_source = 2'd2; a_address = 26'h010;
    @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("bp stall a_ready", {31'd0, a_ready}, 32'd0);
      check("bp stall d_valid", {31'd0, d_valid}, 32'd1);
      check("bp stall d_source", {30'd0, d_source}, 32'd0);
      check("bp stall d_data", d_data, W10);
      @(posedge clock);
    end
    ncyc = 0;
    while ((exp_q.size() > 0 || a_valid) && ncyc < 20) begin
      @(negedge clock);
      d_ready = 1'b1;
      fd = d_valid && d_ready;
      fa = a_valid && a_ready;
      if (fd) begin
        if (exp_q.size() == 0) fail_now("bp unexpected response");
        else begin
          check("bp order d_source", {30'd0, d_source}, {30'd0, exp_q[0][33:32]});
          check("bp order d_data", d_data, exp_q[0][31:0]);
        end
      end
      @(posedge clock);
      if (fd && exp_q.size() > 0) void'(exp_q.pop_front());
      if (fa) begin
        exp_q.push_back({a_source, W10});
        #1 a_valid = 1'b0;
      end
      ncyc++;
    end
    check("bp drained", exp_q.size(), 32'd0);
    exp_q.delete();
    @(negedge clock);
    check("bp idle d_valid", {31'd0, d_valid}, 32'd0);

    // ---- full-throughput streaming ----
    sent = 0; recv = 0; ncyc = 0;
    d_ready = 1'b1;
    while (recv < 16 && ncyc < 60) begin
      @(negedge clock);
      fd = d_valid && d_ready;
      if (sent > 0 && sent < 16) check("stream a_ready", {31'd0, a_ready}, 32'd1);
      if (recv < sent) check("stream d_valid", {31'd0, d_valid}, 32'd1);
      if (fd) begin
        if (exp_q.size() == 0) fail_now("stream unexpected response");
        else begin
          check("stream d_source", {30'd0, d_source}, {30'd0, exp_q[0][33:32]});
          check("stream d_data", d_data, exp_q[0][31:0]);
        end
      end
      if (sent < 16) begin
        a_valid = 1'b1;
        a_source = 2'(sent);
        a_address = sent[0] ? 26'h020 : 26'h010;
      end else begin
        a_valid = 1'b0;
      end
      fa = a_valid && a_ready;
      @(posedge clock);
      if (fd) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        recv++;
      end
      if (fa) begin
        exp_q.push_back({a_source, sent[0] ? W20 : W10});
        sent++;
      end
      ncyc++;
    end
    #1 a_valid = 1'b0;
    d_ready = 1'b0;
    check("stream received", recv, 32'd16);
    check("stream cycles", ncyc, 32'd17);
    exp_q.delete();

    // ---- asynchronous reset with a full queue ----
    send_a(mk(3'd4, 3'd0, 3'd2, 2'd0, 26'h010, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, W10, 1'b0));
    send_a(mk(3'd4, 3'd0, 3'd2, 2'd1, 26'h020, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, W20, 1'b0));
    #1;
    check("full d_valid", {31'd0, d_valid}, 32'd1);
    check("full a_ready", {31'd0, a_ready}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    check("async rst d_valid", {31'd0, d_valid}, 32'd0);
    check("async rst a_ready", {31'd0, a_ready}, 32'd1);
    check("async rst d_data", d_data, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    d_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("post rst no stale", {31'd0, d_valid}, 32'd0);
    end
    d_ready = 1'b0;
    begin
      vec_t v;
      v = mk(3'd4, 3'd0, 3'd2, 2'd3, 26'h010, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, W10, 1'b0);
      send_a(v);
      check_d(v, 99);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
